// File: rtl/trace_event_fifo_if.sv
// -----------------------------------------------------------------------------
// trace_event_fifo_if
//
// Bundles the capture-side and readback-side signals of trace_event_fifo so the
// recorder and whoever drives it (register block, bench) share one definition.
//
// Signals (direction seen from the recorder, i.e. the slave modport):
//   I_arm              in   capture enable (level)
//   I_match            in   per-rule match pulses, several may assert together
//   I_rule_enable      in   per-rule record enable
//   I_rd_en            in   pop the head entry
//   I_clear_flags      in   clear sticky flags, release the overflow block
//   O_rd_data          out  head entry, first-word fall-through
//   O_empty / O_full   out  occupancy status
//   O_count            out  number of entries held
//   O_underflow        out  sticky: pop attempted while empty
//   O_overflow_blocked out  sticky: entry dropped, writes suppressed
// -----------------------------------------------------------------------------
interface trace_event_fifo_if #(
    parameter int pMATCH_RULES     = 8,
    parameter int pTIMESTAMP_WIDTH = 8,
    parameter int pDEPTH           = 32
);

    localparam int pENTRY_WIDTH = pTIMESTAMP_WIDTH + 11;
    localparam int pCOUNT_WIDTH = $clog2(pDEPTH) + 1;

    logic                    I_arm;
    logic [pMATCH_RULES-1:0] I_match;
    logic [pMATCH_RULES-1:0] I_rule_enable;
    logic                    I_rd_en;
    logic                    I_clear_flags;

    logic [pENTRY_WIDTH-1:0] O_rd_data;
    logic                    O_empty;
    logic                    O_full;
    logic [pCOUNT_WIDTH-1:0] O_count;
    logic                    O_underflow;
    logic                    O_overflow_blocked;

    modport master (
        output I_arm, I_match, I_rule_enable, I_rd_en, I_clear_flags,
        input  O_rd_data, O_empty, O_full, O_count, O_underflow, O_overflow_blocked
    );

    modport slave (
        input  I_arm, I_match, I_rule_enable, I_rd_en, I_clear_flags,
        output O_rd_data, O_empty, O_full, O_count, O_underflow, O_overflow_blocked
    );

endinterface

// File: rtl/trace_event_fifo.sv
// -----------------------------------------------------------------------------
// trace_event_fifo
//
// Timestamps per-rule match pulses and queues them for readback. Each entry is
//   [TS+10:TS+9] cmd   (01 event, 10 timestamp roll)
//   [TS+8]       multi (more than one enabled rule hit in the same cycle)
//   [TS+7:TS]    index of the lowest enabled rule that hit
//   [TS-1:0]     cycles since the previous entry (or since arming)
//
// Ports:
//   trace_clk  capture clock
//   resetn     asynchronous active-low reset
//   bus        trace_event_fifo_if.slave (capture inputs, readback outputs)
//
// Build option:
//   TRACE_EVENT_LONG_TS_EN  when defined, a roll entry is written each time the
//                           delta timestamp reaches all-ones without an event,
//                           so arbitrarily long gaps can be reconstructed by
//                           summing timestamps. When undefined the counter just
//                           saturates and the next event records all-ones.
// -----------------------------------------------------------------------------
module trace_event_fifo #(
    parameter int pMATCH_RULES     = 8,
    parameter int pTIMESTAMP_WIDTH = 8,
    parameter int pDEPTH           = 32
) (
    input  logic              trace_clk,
    input  logic              resetn,
    trace_event_fifo_if.slave bus
);

    localparam int pENTRY_WIDTH = pTIMESTAMP_WIDTH + 11;
    localparam int pCOUNT_WIDTH = $clog2(pDEPTH) + 1;
    localparam int pPTR_WIDTH   = $clog2(pDEPTH);

    typedef enum logic [1:0] {
        CMD_EVENT = 2'b01,
        CMD_ROLL  = 2'b10
    } cmd_e;

    typedef logic [pTIMESTAMP_WIDTH-1:0] ts_t;
    typedef logic [pENTRY_WIDTH-1:0]     entry_t;
    typedef logic [pPTR_WIDTH-1:0]       ptr_t;
    typedef logic [pCOUNT_WIDTH-1:0]     count_t;

    localparam ts_t                     TS_MAX     = '1;
    localparam logic [pMATCH_RULES-1:0] RULE_ONE   = pMATCH_RULES'(1);
    localparam count_t                  COUNT_FULL = pCOUNT_WIDTH'(pDEPTH);

    // State
    ts_t    ts_cnt_q,    ts_cnt_d;
    ptr_t   wr_ptr_q,    wr_ptr_d;
    ptr_t   rd_ptr_q,    rd_ptr_d;
    count_t count_q,     count_d;
    entry_t rd_data_q,   rd_data_d;
    logic   underflow_q, underflow_d;
    logic   blocked_q,   blocked_d;

    entry_t mem [pDEPTH];

    // Capture-side decode
    logic [pMATCH_RULES-1:0] hit;
    logic                    any_hit;
    logic                    multi;
    logic [7:0]              rule_idx;
    logic                    event_req;
    logic                    roll_req;
    logic                    wr_req;
    cmd_e                    wr_cmd;
    entry_t                  wr_entry;

    // FIFO control
    logic empty;
    logic full;
    logic pop;
    logic wr_acc;
    logic overflow;

    assign hit     = bus.I_match & bus.I_rule_enable;
    assign any_hit = |hit;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi   = |(hit & (hit - RULE_ONE));

    // NOTE: every signal written in an always_comb gets a default before any
    // condition; a path that skips the assignment would infer a latch.
    always_comb begin
        rule_idx = '0;
        // Scan downwards so the lowest set index is the one that sticks.
        for (int i = pMATCH_RULES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                rule_idx = 8'(i);
            end
        end
    end

    assign event_req = bus.I_arm & any_hit & ~blocked_q;

`ifdef TRACE_EVENT_LONG_TS_EN
    // A roll only fills an otherwise idle cycle; an event always takes the slot.
    assign roll_req = bus.I_arm & ~any_hit & ~blocked_q & (ts_cnt_q == TS_MAX);
`else
    assign roll_req = 1'b0;
`endif

    assign wr_req   = event_req | roll_req;
    assign wr_cmd   = event_req ? CMD_EVENT : CMD_ROLL;
    assign wr_entry = event_req ? {wr_cmd, multi, rule_idx, ts_cnt_q}
                                : {wr_cmd, 1'b0, 8'd0, TS_MAX};

    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_FULL);
    assign pop      = bus.I_rd_en & ~empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
    assign wr_acc   = wr_req & (~full | bus.I_rd_en);
    assign overflow = wr_req & full & ~bus.I_rd_en;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        ts_cnt_d    = ts_cnt_q;
        underflow_d = underflow_q;
        blocked_d   = blocked_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + pPTR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + pPTR_WIDTH'(1);
        end

        if (wr_acc && !pop) begin
            count_d = count_q + pCOUNT_WIDTH'(1);
        end else if (!wr_acc && pop) begin
            count_d = count_q - pCOUNT_WIDTH'(1);
        end

        // Registered head: the incoming entry becomes the head when nothing
        // older survives this cycle; otherwise a pop advances to the next
        // stored entry. When the FIFO drains, the last value is held.
        if (wr_acc && (empty || (count_q == pCOUNT_WIDTH'(1) && pop))) begin
            rd_data_d = wr_entry;
        end else if (pop && count_q > pCOUNT_WIDTH'(1)) begin
            rd_data_d = mem[rd_ptr_d];
        end

        if (bus.I_clear_flags || !bus.I_arm) begin
            ts_cnt_d = '0;
        end else if (wr_acc) begin
            ts_cnt_d = ts_t'(1);
        end else if (ts_cnt_q != TS_MAX) begin
            ts_cnt_d = ts_cnt_q + ts_t'(1);
        end

        // Clear wins over a set arriving in the same cycle.
        if (bus.I_clear_flags) begin
            underflow_d = 1'b0;
            blocked_d   = 1'b0;
        end else begin
            underflow_d = underflow_q | (bus.I_rd_en & empty);
            blocked_d   = blocked_q | overflow;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            ts_cnt_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            underflow_q <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            underflow_q <= underflow_d;
            blocked_q   <= blocked_d;
        end
    end

    // NOTE: the storage array has no reset; pointers and count define which
    // words are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge trace_clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

    assign bus.O_rd_data          = rd_data_q;
    assign bus.O_empty            = empty;
    assign bus.O_full             = full;
    assign bus.O_count            = count_q;
    assign bus.O_underflow        = underflow_q;
    assign bus.O_overflow_blocked = blocked_q;

endmodule

// File: tb/tb_trace_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_trace_event_fifo
//
// Self-checking bench for trace_event_fifo with default parameters. Expected
// entries are queued when the stimulus that creates them is driven and are
// compared against the head when popped. Expectations for long gaps follow
// TRACE_EVENT_LONG_TS_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_trace_event_fifo;

    localparam int R  = 8;
    localparam int TS = 8;
    localparam int D  = 32;
    localparam int EW = TS + 11;
    localparam int CW = $clog2(D) + 1;

    localparam logic [1:0] EV   = 2'b01;
    localparam logic [1:0] ROLL = 2'b10;

    logic trace_clk = 1'b0;
    logic resetn;

    trace_event_fifo_if #(
        .pMATCH_RULES(R), .pTIMESTAMP_WIDTH(TS), .pDEPTH(D)
    ) bus ();

    trace_event_fifo #(
        .pMATCH_RULES(R), .pTIMESTAMP_WIDTH(TS), .pDEPTH(D)
    ) dut (
        .trace_clk (trace_clk),
        .resetn    (resetn),
        .bus       (bus)
    );

    always #5 trace_clk = ~trace_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] sb [$];
    logic [EW-1:0] last_popped;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk(input logic [1:0] cmd, input logic multi,
                                         input logic [7:0] rule, input logic [TS-1:0] ts);
        return {cmd, multi, rule, ts};
    endfunction

    // Inputs change and outputs are sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge trace_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse(input logic [R-1:0] m);
        bus.I_match = m;
        tick();
        bus.I_match = '0;
    endtask

    task automatic pop_expect(input string tag);
        logic [EW-1:0] exp;
        exp = sb.pop_front();
        check({tag, " head"}, bus.O_rd_data, exp);
        bus.I_rd_en = 1'b1;
        tick();
        bus.I_rd_en = 1'b0;
        last_popped = exp;
    endtask

    task automatic drain(input string tag);
        while (sb.size() != 0) pop_expect(tag);
        check({tag, " empty after drain"}, bus.O_empty, 1);
        check({tag, " count after drain"}, bus.O_count, 0);
    endtask

    task automatic clear_flags();
        bus.I_clear_flags = 1'b1;
        tick();
        bus.I_clear_flags = 1'b0;
    endtask

    initial begin
        bus.I_arm         = 1'b0;
        bus.I_match       = '0;
        bus.I_rule_enable = '1;
        bus.I_rd_en       = 1'b0;
        bus.I_clear_flags = 1'b0;
        last_popped       = '0;
        resetn            = 1'b0;
        #12;

        // Reset values
        check("reset rd_data",   bus.O_rd_data, 0);
        check("reset empty",     bus.O_empty, 1);
        check("reset full",      bus.O_full, 0);
        check("reset count",     bus.O_count, 0);
        check("reset underflow", bus.O_underflow, 0);
        check("reset blocked",   bus.O_overflow_blocked, 0);
        resetn = 1'b1;
        tick();

        // Basic timestamps: rule 2 on the 6th armed edge, rule 0 three later
        bus.I_arm = 1'b1;
        idle(5);
        pulse(8'b0000_0100);
        sb.push_back(mk(EV, 1'b0, 8'd2, 8'd5));
        check("s1 latency head",  bus.O_rd_data, mk(EV, 1'b0, 8'd2, 8'd5));
        check("s1 latency count", bus.O_count, 1);
        check("s1 latency empty", bus.O_empty, 0);
        idle(2);
        pulse(8'b0000_0001);
        sb.push_back(mk(EV, 1'b0, 8'd0, 8'd3));
        check("s1 count", bus.O_count, 2);
        bus.I_arm = 1'b0;
        pulse(8'hFF);
        check("s1 disarmed ignores match", bus.O_count, 2);
        drain("s1");

        // Simultaneous hits, then the same hits with rule 1 disabled
        bus.I_arm   = 1'b1;
        bus.I_match = 8'b0001_0010;
        tick();
        sb.push_back(mk(EV, 1'b1, 8'd1, 8'd0));
        bus.I_rule_enable = 8'b1111_1101;
        tick();
        sb.push_back(mk(EV, 1'b0, 8'd4, 8'd1));
        bus.I_match       = '0;
        bus.I_rule_enable = '1;
        bus.I_arm         = 1'b0;
        check("s2 count", bus.O_count, 2);
        drain("s2");

        // Long gap: 600 idle armed cycles, then rule 3
        bus.I_arm = 1'b1;
        idle(600);
        pulse(8'b0000_1000);
`ifdef TRACE_EVENT_LONG_TS_EN
        sb.push_back(mk(ROLL, 1'b0, 8'd0, 8'd255));
        sb.push_back(mk(ROLL, 1'b0, 8'd0, 8'd255));
        sb.push_back(mk(EV,   1'b0, 8'd3, 8'd90));
        check("s3 count", bus.O_count, 3);
`else
        sb.push_back(mk(EV, 1'b0, 8'd3, 8'd255));
        check("s3 count", bus.O_count, 1);
`endif
        bus.I_arm = 1'b0;
        drain("s3");

        // Overflow: 33 back-to-back events with no reads
        bus.I_arm   = 1'b1;
        bus.I_match = 8'b0000_0001;
        for (int i = 0; i < 33; i++) begin
            tick();
            if (i < 32) sb.push_back(mk(EV, 1'b0, 8'd0, (i == 0) ? 8'd0 : 8'd1));
        end
        check("s4 full",    bus.O_full, 1);
        check("s4 count",   bus.O_count, D);
        check("s4 blocked", bus.O_overflow_blocked, 1);
        idle(3);
        check("s4 blocked count",   bus.O_count, D);
        check("s4 blocked remains", bus.O_overflow_blocked, 1);
        bus.I_match = '0;
        clear_flags();
        check("s4 clear blocked", bus.O_overflow_blocked, 0);
        check("s4 clear count",   bus.O_count, D);
        // Full with a pop in the same cycle: write accepted, count unchanged
        check("s4 full+rd head", bus.O_rd_data, sb[0]);
        last_popped = sb.pop_front();
        bus.I_match = 8'b0000_0001;
        bus.I_rd_en = 1'b1;
        tick();
        sb.push_back(mk(EV, 1'b0, 8'd0, 8'd0));
        bus.I_match = '0;
        bus.I_rd_en = 1'b0;
        check("s4 full+rd count",   bus.O_count, D);
        check("s4 full+rd full",    bus.O_full, 1);
        check("s4 full+rd blocked", bus.O_overflow_blocked, 0);
        bus.I_arm = 1'b0;
        drain("s4");

        // Underflow: pop while empty leaves the head untouched
        bus.I_rd_en = 1'b1;
        tick();
        bus.I_rd_en = 1'b0;
        check("s5 underflow set",  bus.O_underflow, 1);
        check("s5 head unchanged", bus.O_rd_data, last_popped);
        check("s5 empty",          bus.O_empty, 1);
        clear_flags();
        check("s5 underflow clear", bus.O_underflow, 0);
        // Pop while empty with a write in the same cycle: write accepted
        bus.I_arm   = 1'b1;
        bus.I_match = 8'b0100_0000;
        bus.I_rd_en = 1'b1;
        tick();
        sb.push_back(mk(EV, 1'b0, 8'd6, 8'd0));
        bus.I_match = '0;
        bus.I_rd_en = 1'b0;
        bus.I_arm   = 1'b0;
        check("s5 underflow+wr flag",  bus.O_underflow, 1);
        check("s5 underflow+wr count", bus.O_count, 1);
        drain("s5");
        clear_flags();

        // Asynchronous reset with 10 entries queued
        bus.I_arm   = 1'b1;
        bus.I_match = 8'b0000_0001;
        idle(10);
        bus.I_match = '0;
        bus.I_arm   = 1'b0;
        check("s6 count before reset", bus.O_count, 10);
        #3;
        resetn = 1'b0;
        #1;
        check("s6 async rd_data",   bus.O_rd_data, 0);
        check("s6 async empty",     bus.O_empty, 1);
        check("s6 async full",      bus.O_full, 0);
        check("s6 async count",     bus.O_count, 0);
        check("s6 async underflow", bus.O_underflow, 0);
        check("s6 async blocked",   bus.O_overflow_blocked, 0);
        sb.delete();
        #3;
        resetn = 1'b1;
        tick();
        check("s6 post reset empty", bus.O_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trace_event_fifo.md
# trace_event_fifo

Capture-side event recorder for the trace sniffer: timestamps per-rule match pulses from the pattern matchers and queues them for USB readback via the sniff-FIFO read register. A parametrised successor to the fixed 8-rule/8-bit-timestamp sniff FIFO: configurable rule count, timestamp width and depth, simultaneous-match reporting, and long-gap timestamp roll entries. Sits between the match-rule comparators and the register block, entirely in the trace clock domain.

## Interface

Parameters:
- pMATCH_RULES, 8: number of match-rule inputs (1..8)
- pTIMESTAMP_WIDTH, 8: delta-timestamp field width (4..24)
- pDEPTH, 32: FIFO entries, power of 2 (4..512)
- Derived: pENTRY_WIDTH = pTIMESTAMP_WIDTH + 11; pCOUNT_WIDTH = clog2(pDEPTH)+1

Ports (one clock `trace_clk`; reset `resetn` asynchronous, active-low):
- trace_clk  in  1  capture clock
- resetn  in  1  async active-low reset
- I_arm  in  1  capture enable (level)
- I_match  in  pMATCH_RULES  per-rule match pulses, multiple may assert per cycle
- I_rule_enable  in  pMATCH_RULES  per-rule record enable
- I_rd_en  in  1  pop head entry
- I_clear_flags  in  1  clear sticky flags, release overflow block
- O_rd_data  out  pENTRY_WIDTH  head entry (first-word fall-through)
- O_empty  out  1
- O_full  out  1
- O_count  out  pCOUNT_WIDTH  entries held
- O_underflow  out  1  sticky
- O_overflow_blocked  out  1  sticky

## Operation

- Entry layout: [TS+10:TS+9] cmd (2'b01 event, 2'b10 roll); [TS+8] multi; [TS+7:TS] rule index; [TS-1:0] timestamp. With TS=8, rule is at [15:8], timestamp at [7:0].
- hit = I_match & I_rule_enable. Event if hit != 0, I_arm=1, not blocked.
- Event entry: rule = lowest set index of hit; multi = 1 if more than one bit set; timestamp = ts_cnt.
- ts_cnt: 0 while I_arm=0; 1 after any write cycle; else +1, saturating at all-ones. Timestamp = cycles since previous entry (first event: cycles since I_arm was first sampled high).
- Roll entry (macro enabled): ts_cnt = all-ones, armed, no event -> write cmd 2'b10, rule 0, multi 0, ts all-ones; ts_cnt -> 1. An event in the same cycle wins; no roll is written.
- At most one write per cycle.
- Full and write requested without I_rd_en -> entry dropped; O_overflow_blocked set; all further writes suppressed until I_clear_flags. FIFO contents are retained.
- Full with I_rd_en in the same cycle -> write accepted; count unchanged.
- I_rd_en while empty -> O_underflow set; O_rd_data unchanged; a write in the same cycle is accepted.
- I_clear_flags clears both sticky flags and ts_cnt -> 0; it takes priority over a flag set in the same cycle.
- I_arm falling -> no new writes and ts_cnt held at 0; queued entries remain readable.

## Timing

- Reset values: O_rd_data 0, O_empty 1, O_full 0, O_count 0, both sticky flags 0, ts_cnt 0, pointers 0.
- Write latency: an entry created in cycle n is visible on O_rd_data in cycle n+1, with O_empty low and O_count incremented.
- Pop: after I_rd_en in cycle n, the next entry (or O_empty=1) is presented in cycle n+1.
- Pointers wrap modulo pDEPTH. O_full = (O_count == pDEPTH).
- Reset asserted mid-capture clears everything immediately, regardless of clock.

## Configuration

- TRACE_EVENT_LONG_TS_EN defined: roll entries are generated as described; gaps of any length are reconstructable by summing timestamps.
- Not defined: no roll entries; ts_cnt saturates at all-ones and the event records the saturated value. Cmd 2'b10 never appears.

## Test plan

All scenarios use defaults and the macro enabled unless noted.

- Arm, pulse rule 2 at cycle 5, then rule 0 at cycle 8 -> entries {01,0,2,5}, {01,0,0,3}; O_count=2.
- Rules 1 and 4 hit in the same cycle with both enabled -> one entry, rule=1, multi=1; with rule 1 disabled -> rule=4, multi=0.
- Armed with no events for 600 cycles, then rule 3 -> roll entries with ts=255 (x2), then event rule 3, ts=600-510=90. Without the macro: a single event with ts=255.
- 33 events with no reads -> O_full=1, O_count=32, O_overflow_blocked=1; the 33rd event is dropped; later events are ignored until I_clear_flags.
- Pop while empty -> O_underflow=1; O_rd_data unchanged; the flag clears on I_clear_flags.
- Assert resetn=0 with 10 entries queued -> all outputs return to reset values asynchronously.
